axis_vec_sender: RTL

Streams a fixed-length vector of 32-bit words (fp32 bit patterns) out as one AXI4-Stream packet, asserting TLAST on the final word. It is the hardware transmitter feeding the INPUT_AXIS port of accel_dot, so on-chip logic can drive the dot-product accelerator without a host-side DMA. A start pulse snapshots a parallel vector. The block then transmits it word by word, honoring TREADY backpressure, and pulses done when the last word is accepted.

---
 rtl/axis_vec_sender.sv | 107 ++++++++++
 1 files changed

// File: rtl/axis_vec_sender.sv
// rtl/axis_vec_sender.sv - streams a captured LEN-word vector as one AXI4-Stream packet
//
// Purpose: on an accepted start, snapshots `vec` into an internal buffer and
// sends it word by word on OUTPUT_AXIS_*, honoring TREADY backpressure and
// asserting TLAST on the final word. done pulses for one cycle after the
// final handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   vec                 LEN x DATA_WIDTH vector, sampled only on accepted start
//   start               send request, honored only in IDLE
//   busy                high while a packet is in flight (SEND)
//   done                one-cycle pulse after the last word's handshake
//   OUTPUT_AXIS_TDATA   current word (0 when idle)
//   OUTPUT_AXIS_TLAST   high with word LEN-1 only
//   OUTPUT_AXIS_TVALID  word valid
//   OUTPUT_AXIS_TREADY  downstream accepts
module axis_vec_sender #(
  parameter int LEN        = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [0:LEN-1][DATA_WIDTH-1:0]  vec,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH-1:0]           OUTPUT_AXIS_TDATA,
  output logic                            OUTPUT_AXIS_TLAST,
  output logic                            OUTPUT_AXIS_TVALID,
  input  logic                            OUTPUT_AXIS_TREADY
);

  localparam int              IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [IDX_W-1:0]               idx_nxt;
  logic                           done_nxt;
  logic                           capture;
  logic                           at_last;
  logic [0:LEN-1][DATA_WIDTH-1:0] vec_buf;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (OUTPUT_AXIS_TREADY) begin
          if (at_last) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer content is irrelevant until the next capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      vec_buf <= vec;
    end
  end

  // All stream outputs are decoded from registered state, so the async reset
  // drops them immediately and nothing depends combinationally on TREADY.
  assign busy               = (state == SEND);
  assign OUTPUT_AXIS_TVALID = (state == SEND);
  assign OUTPUT_AXIS_TLAST  = (state == SEND) && at_last;
  assign OUTPUT_AXIS_TDATA  = (state == SEND) ? vec_buf[idx] : '0;

endmodule
